// File: rtl/fc_pkg.sv
// fc_pkg -- definitions shared by the fully-connected layer feeders.
//
// Contents:
//   fc_state_e : feeder FSM states (FILL -> SETTLE -> OUT -> FILL).
//   fc_zw()    : width of a layer result, i.e. the product width
//                (2*width) plus enough carry bits to sum n products.
package fc_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } fc_state_e;

    function automatic int fc_zw(input int width, input int n);
        return width * 2 + $clog2(n);
    endfunction

endpackage

// File: rtl/fc_stream_feeder.sv
// fc_stream_feeder -- turns a serial stream of activation words into the
// parallel vector x of a combinational fully-connected layer. It waits a
// fixed number of cycles for the layer to settle, then registers the
// result z and offers it downstream.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready     upstream word handshake (s_data, s_last)
//   x[0:IN-1]           registered activation vector, held constant
//                       while the layer settles and the result is offered
//   z                   combinational layer result computed from x
//   m_valid/m_ready     downstream result handshake (m_data)
//   err_short           sticky: s_last arrived before word IN-1
//   err_long            sticky: word IN-1 arrived without s_last
//
// Handshakes: a transfer takes place on a rising edge where valid and
// ready are both 1. The producer holds valid and data until that edge;
// ready never depends on valid in the same cycle.
module fc_stream_feeder
    import fc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int IN         = 400,
    parameter int ZW         = fc_zw(WIDTH, IN),
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] x [0:IN-1],
    input  logic [ZW-1:0]    z,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ZW-1:0]    m_data,
    output logic             err_short,
    output logic             err_long
);

    localparam int CW  = (IN > 1) ? $clog2(IN) : 1;
    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [CW-1:0]  CNT_LAST   = CW'(IN - 1);
    localparam logic [SCW-1:0] SETTLE_MAX = SCW'(SETTLE_CYC - 1);

    fc_state_e      state;
    fc_state_e      state_next;
    logic [CW-1:0]  cnt;
    logic [SCW-1:0] settle_cnt;

    logic s_fire;
    logic m_fire;
    logic frame_end;

    assign s_fire    = s_valid && s_ready;
    assign m_fire    = m_valid && m_ready;
    // A frame ends on s_last or when the vector is full, whichever comes first.
    assign frame_end = s_last || (cnt == CNT_LAST);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (s_fire && frame_end) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (m_ready) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs (pure state decode, so both are glitch-free with
    // respect to the handshake inputs)
    // ---------------------------------------------------------------
    always_comb begin
        s_ready = (state == FILL);
        m_valid = (state == OUT);
    end

    // ---------------------------------------------------------------
    // Datapath: word counter, settle counter, vector, result, flags
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            settle_cnt <= '0;
            m_data     <= '0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            for (int i = 0; i < IN; i++) begin
                x[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (s_fire) begin
                        x[cnt] <= s_data;
                        if (frame_end) begin
                            cnt        <= '0;
                            settle_cnt <= SETTLE_MAX;
                            if (s_last && (cnt != CNT_LAST)) begin
                                err_short <= 1'b1;
                            end
                            if (!s_last && (cnt == CNT_LAST)) begin
                                err_long <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end else begin
                        m_data <= z;
                    end
                end
                OUT: begin
                    // Clearing here leaves unwritten entries of a short
                    // next frame at zero.
                    if (m_fire) begin
                        for (int i = 0; i < IN; i++) begin
                            x[i] <= '0;
                        end
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
